// File: rtl/lcd_bus_receiver.sv
// Display-side receiver for the lcd_data/lcd_rs/lcd_enable bus: decodes commands and characters into a display RAM.
// Writes act 3 clocks after enable falls; writes arriving while busy are dropped and flagged as overrun.
module lcd_bus_receiver #(
  parameter int DEPTH = 32,
  parameter int EXEC_CYCLES = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    lcd_data,
  input  logic          lcd_enable,
  input  logic          lcd_rs,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_char,
  output logic [AW-1:0] cursor,
  output logic          display_on,
  output logic          inc_mode,
  output logic          busy,
  output logic          wr_strobe,
  output logic          overrun,
  output logic          bad_cmd
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {CLEAR, IDLE, EXEC} state_t;

  state_t          state;
  logic            en_s1, en_s2, en_s3;
  logic            rs_s1, rs_s2;
  logic [7:0]      dat_s1, dat_s2;
  logic            evt, evt_rs;
  logic [7:0]      evt_dat;
  logic [AW-1:0]   clr_addr;
  logic [CW-1:0]   cnt;
  logic [7:0]      ram [DEPTH];
  logic            accept;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [7:0]      ram_wdata;

  // Two-flop sync, third enable flop for fall detect, then one register holding the detected write.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_s1   <= 1'b0;
      en_s2   <= 1'b0;
      en_s3   <= 1'b0;
      rs_s1   <= 1'b0;
      rs_s2   <= 1'b0;
      dat_s1  <= 8'h00;
      dat_s2  <= 8'h00;
      evt     <= 1'b0;
      evt_rs  <= 1'b0;
      evt_dat <= 8'h00;
    end else begin
      en_s1   <= lcd_enable;
      en_s2   <= en_s1;
      en_s3   <= en_s2;
      rs_s1   <= lcd_rs;
      rs_s2   <= rs_s1;
      dat_s1  <= lcd_data;
      dat_s2  <= dat_s1;
      evt     <= !en_s2 && en_s3;
      evt_rs  <= rs_s2;
      evt_dat <= dat_s2;
    end
  end

  always_comb begin
    accept    = evt && (state == IDLE);
    ram_we    = !reset && ((state == CLEAR) || (accept && evt_rs));
    ram_waddr = (state == CLEAR) ? clr_addr : cursor;
    ram_wdata = (state == CLEAR) ? 8'h20 : evt_dat;
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_char <= 8'h20;
    else       rd_char <= ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      cnt        <= '0;
      cursor     <= '0;
      display_on <= 1'b0;
      inc_mode   <= 1'b1;
      busy       <= 1'b1;
      wr_strobe  <= 1'b0;
      overrun    <= 1'b0;
      bad_cmd    <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      overrun   <= 1'b0;
      bad_cmd   <= 1'b0;
      case (state)
        CLEAR: begin
          overrun  <= evt;
          clr_addr <= clr_addr + AW'(1);
          if (clr_addr == AW'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        EXEC: begin
          overrun <= evt;
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        IDLE: begin
          if (evt) begin
            wr_strobe <= 1'b1;
            busy      <= 1'b1;
            state     <= EXEC;
            cnt       <= CW'(EXEC_CYCLES - 1);
            if (evt_rs) begin
              cursor <= inc_mode ? cursor + AW'(1) : cursor - AW'(1);
            end else if (evt_dat == 8'h01) begin
              cursor   <= '0;
              inc_mode <= 1'b1;
              clr_addr <= '0;
              state    <= CLEAR;
            end else if (evt_dat[7:1] == 7'b0000001) begin
              cursor <= '0;
            end else if (evt_dat[7:2] == 6'b000001) begin
              inc_mode <= evt_dat[1];
            end else if (evt_dat[7:3] == 5'b00001) begin
              display_on <= evt_dat[2];
            end else if (evt_dat[7]) begin
              cursor <= evt_dat[AW-1:0];
            end else begin
              bad_cmd <= 1'b1;
            end
          end
        end
        default: begin
          state    <= CLEAR;
          clr_addr <= '0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: bus writes with hand-computed expected RAM/cursor/flag values.
module tb_lcd_bus_receiver;

  logic       clk;
  logic       reset;
  logic [7:0] lcd_data;
  logic       lcd_enable;
  logic       lcd_rs;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [4:0] cursor;
  logic       display_on;
  logic       inc_mode;
  logic       busy;
  logic       wr_strobe;
  logic       overrun;
  logic       bad_cmd;

  int checks = 0;
  int failures = 0;

  lcd_bus_receiver #(.DEPTH(32), .EXEC_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .lcd_data(lcd_data), .lcd_enable(lcd_enable),
    .lcd_rs(lcd_rs), .rd_addr(rd_addr), .rd_char(rd_char), .cursor(cursor),
    .display_on(display_on), .inc_mode(inc_mode), .busy(busy),
    .wr_strobe(wr_strobe), .overrun(overrun), .bad_cmd(bad_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a byte with enable high for 3 clocks, then drop enable; returns just after the drop.
  task automatic bus_fall(input logic rs, input logic [7:0] d);
    lcd_rs = rs;
    lcd_data = d;
    lcd_enable = 1'b1;
    repeat (3) tick();
    lcd_enable = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
      failures++;
    end
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d);
    bus_fall(rs, d);
    repeat (4) tick();
    wait_idle();
  endtask

  task automatic read_ram(input logic [4:0] a, output logic [7:0] v);
    rd_addr = a;
    tick();
    v = rd_char;
  endtask

  task automatic check_all_blank(input string tag);
    logic [7:0] v;
    for (int a = 0; a < 32; a++) begin
      read_ram(5'(a), v);
      checks++;
      if (v !== 8'h20) begin
        $display("FAIL %s ram[%0d]: got %h, required 20", tag, a, v);
        failures++;
      end
    end
  endtask

  task automatic test_reset;
    int ov = 0;
    reset = 1'b1;
    lcd_enable = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, cursor, display_on, inc_mode, wr_strobe, overrun, bad_cmd, rd_char} !==
        {1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20}) begin
      $display("FAIL reset_state: busy=%b cursor=%0d disp=%b inc=%b strb=%b ovr=%b bad=%b rd=%h, required 1 0 0 1 0 0 0 20",
               busy, cursor, display_on, inc_mode, wr_strobe, overrun, bad_cmd, rd_char);
      failures++;
    end
    reset = 1'b0;
    repeat (31) begin
      tick();
      if (overrun) ov++;
    end
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL clear_busy_31: busy=%b, required 1", busy);
      failures++;
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL clear_busy_32: busy=%b, required 0", busy);
      failures++;
    end
    checks++;
    if (ov !== 0) begin
      $display("FAIL idle_high_no_fall: overrun pulses=%0d, required 0", ov);
      failures++;
    end
    checks++;
    if ({cursor, inc_mode, display_on} !== {5'd0, 1'b1, 1'b0}) begin
      $display("FAIL post_reset_regs: cursor=%0d inc=%b disp=%b, required 0 1 0", cursor, inc_mode, display_on);
      failures++;
    end
    check_all_blank("reset_ram");
  endtask

  task automatic test_char_writes;
    logic [7:0] v;
    logic [7:0] chars [2];
    chars[0] = 8'h50;
    chars[1] = 8'h41;
    for (int k = 0; k < 2; k++) begin
      bus_fall(1'b1, chars[k]);
      repeat (3) tick();
      checks++;
      if (wr_strobe !== 1'b0) begin
        $display("FAIL strobe_early[%0d]: wr_strobe=%b, required 0", k, wr_strobe);
        failures++;
      end
      tick();
      checks++;
      if ({wr_strobe, busy} !== 2'b11) begin
        $display("FAIL strobe_at_3[%0d]: wr_strobe=%b busy=%b, required 1 1", k, wr_strobe, busy);
        failures++;
      end
      tick();
      checks++;
      if (wr_strobe !== 1'b0) begin
        $display("FAIL strobe_width[%0d]: wr_strobe=%b, required 0", k, wr_strobe);
        failures++;
      end
      repeat (6) tick();
      checks++;
      if (busy !== 1'b1) begin
        $display("FAIL exec_busy_8[%0d]: busy=%b, required 1", k, busy);
        failures++;
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
        $display("FAIL exec_done_9[%0d]: busy=%b, required 0", k, busy);
        failures++;
      end
    end
    checks++;
    if (cursor !== 5'd2) begin
      $display("FAIL chars_cursor: got %0d, required 2", cursor);
      failures++;
    end
    for (int k = 0; k < 2; k++) begin
      read_ram(5'(k), v);
      checks++;
      if (v !== chars[k]) begin
        $display("FAIL chars_ram[%0d]: got %h, required %h", k, v, chars[k]);
        failures++;
      end
    end
  endtask

  task automatic test_entry_wrap;
    logic [7:0] v;
    logic [4:0] exp_cur [3];
    logic [7:0] wrap_chars [3];
    exp_cur[0] = 5'd30;
    exp_cur[1] = 5'd31;
    exp_cur[2] = 5'd0;
    wrap_chars[0] = 8'h61;
    wrap_chars[1] = 8'h62;
    wrap_chars[2] = 8'h63;
    do_write(1'b0, 8'h9F);
    checks++;
    if (cursor !== 5'd31) begin
      $display("FAIL set_addr: cursor=%0d, required 31", cursor);
      failures++;
    end
    do_write(1'b0, 8'h04);
    checks++;
    if (inc_mode !== 1'b0) begin
      $display("FAIL entry_dec: inc_mode=%b, required 0", inc_mode);
      failures++;
    end
    do_write(1'b1, 8'h58);
    do_write(1'b1, 8'h59);
    checks++;
    if (cursor !== 5'd29) begin
      $display("FAIL dec_cursor: cursor=%0d, required 29", cursor);
      failures++;
    end
    read_ram(5'd31, v);
    checks++;
    if (v !== 8'h58) begin
      $display("FAIL dec_ram31: got %h, required 58", v);
      failures++;
    end
    read_ram(5'd30, v);
    checks++;
    if (v !== 8'h59) begin
      $display("FAIL dec_ram30: got %h, required 59", v);
      failures++;
    end
    do_write(1'b0, 8'h06);
    for (int k = 0; k < 3; k++) begin
      do_write(1'b1, wrap_chars[k]);
      checks++;
      if (cursor !== exp_cur[k]) begin
        $display("FAIL wrap_cursor[%0d]: got %0d, required %0d", k, cursor, exp_cur[k]);
        failures++;
      end
    end
    read_ram(5'd31, v);
    checks++;
    if (v !== 8'h63) begin
      $display("FAIL wrap_ram31: got %h, required 63", v);
      failures++;
    end
  endtask

  task automatic test_overrun;
    logic [7:0] v;
    bus_fall(1'b1, 8'h51);
    tick();
    tick();
    lcd_data = 8'h52;
    lcd_enable = 1'b1;
    tick();
    tick();
    checks++;
    if (wr_strobe !== 1'b1) begin
      $display("FAIL ovr_first_accept: wr_strobe=%b, required 1", wr_strobe);
      failures++;
    end
    lcd_enable = 1'b0;
    repeat (3) tick();
    checks++;
    if (overrun !== 1'b0) begin
      $display("FAIL ovr_early: overrun=%b, required 0", overrun);
      failures++;
    end
    tick();
    checks++;
    if ({overrun, wr_strobe} !== 2'b10) begin
      $display("FAIL ovr_pulse: overrun=%b wr_strobe=%b, required 1 0", overrun, wr_strobe);
      failures++;
    end
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      $display("FAIL ovr_width: overrun=%b, required 0", overrun);
      failures++;
    end
    wait_idle();
    checks++;
    if (cursor !== 5'd1) begin
      $display("FAIL ovr_cursor: cursor=%0d, required 1", cursor);
      failures++;
    end
    read_ram(5'd0, v);
    checks++;
    if (v !== 8'h51) begin
      $display("FAIL ovr_ram0: got %h, required 51", v);
      failures++;
    end
    read_ram(5'd1, v);
    checks++;
    if (v !== 8'h41) begin
      $display("FAIL ovr_ram1: got %h, required 41", v);
      failures++;
    end
  endtask

  task automatic test_commands;
    do_write(1'b0, 8'h0C);
    checks++;
    if (display_on !== 1'b1) begin
      $display("FAIL disp_on: display_on=%b, required 1", display_on);
      failures++;
    end
    bus_fall(1'b0, 8'h40);
    repeat (4) tick();
    checks++;
    if ({bad_cmd, wr_strobe} !== 2'b11) begin
      $display("FAIL bad_pulse: bad_cmd=%b wr_strobe=%b, required 1 1", bad_cmd, wr_strobe);
      failures++;
    end
    tick();
    checks++;
    if (bad_cmd !== 1'b0) begin
      $display("FAIL bad_width: bad_cmd=%b, required 0", bad_cmd);
      failures++;
    end
    wait_idle();
    checks++;
    if ({cursor, inc_mode, display_on} !== {5'd1, 1'b1, 1'b1}) begin
      $display("FAIL bad_nochange: cursor=%0d inc=%b disp=%b, required 1 1 1", cursor, inc_mode, display_on);
      failures++;
    end
    do_write(1'b0, 8'h05);
    checks++;
    if (inc_mode !== 1'b0) begin
      $display("FAIL entry_05: inc_mode=%b, required 0", inc_mode);
      failures++;
    end
    bus_fall(1'b0, 8'h01);
    repeat (4) tick();
    checks++;
    if ({busy, cursor, inc_mode} !== {1'b1, 5'd0, 1'b1}) begin
      $display("FAIL clr_accept: busy=%b cursor=%0d inc=%b, required 1 0 1", busy, cursor, inc_mode);
      failures++;
    end
    repeat (31) tick();
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL clr_busy_31: busy=%b, required 1", busy);
      failures++;
    end
    tick();
    checks++;
    if ({busy, display_on} !== 2'b01) begin
      $display("FAIL clr_done_32: busy=%b display_on=%b, required 0 1", busy, display_on);
      failures++;
    end
    check_all_blank("cmd_clear");
  endtask

  task automatic test_reset_mid_clear;
    logic [7:0] v;
    do_write(1'b0, 8'h9F);
    do_write(1'b1, 8'h5A);
    read_ram(5'd31, v);
    checks++;
    if (v !== 8'h5A) begin
      $display("FAIL pre_clear_ram31: got %h, required 5a", v);
      failures++;
    end
    bus_fall(1'b0, 8'h01);
    repeat (4) tick();
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (31) tick();
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL rst_clr_busy_31: busy=%b, required 1", busy);
      failures++;
    end
    tick();
    checks++;
    if ({busy, display_on, cursor} !== {1'b0, 1'b0, 5'd0}) begin
      $display("FAIL rst_clr_done: busy=%b disp=%b cursor=%0d, required 0 0 0", busy, display_on, cursor);
      failures++;
    end
    check_all_blank("rst_clear");
  endtask

  initial begin
    reset = 1'b1;
    lcd_data = 8'h00;
    lcd_enable = 1'b0;
    lcd_rs = 1'b0;
    rd_addr = 5'd0;
    test_reset();
    test_char_writes();
    test_entry_wrap();
    test_overrun();
    test_commands();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
